// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one combinational-read data memory port between the CPU
// memory stage (default priority) and a secondary bus master (DMA/debug loader).
// A starvation counter guarantees the DMA a slot; a bounded lock lets the DMA
// keep the port for back-to-back transfers while the CPU is stalled.
// Optional feature macro: DMEM_ARB_STATS_EN (stall / DMA-grant statistics counters).
module dmem_arbiter #(
    parameter int unsigned WD           = 32,
    parameter int unsigned WAM          = 17,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned LOCK_MAX     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    // CPU memory stage
    input  logic          memreadM,
    input  logic          memwriteM,
    input  logic [WAM:0]  aluresultM,
    input  logic [WD-1:0] writedataM,
    input  logic [2:0]    memctrlM,
    output logic [WD-1:0] readdataM,
    output logic          stallM,
    // secondary master
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [WAM:0]  dma_addr,
    input  logic [WD-1:0] dma_wdata,
    input  logic [2:0]    dma_ctrl,
    input  logic          dma_lock,
    output logic          dma_gnt,
    output logic [WD-1:0] dma_rdata,
    output logic          dma_rvalid,
    // memory port
    output logic [WAM:0]  mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [2:0]    mem_ctrl,
    output logic [WD-1:0] mem_wdata,
    input  logic [WD-1:0] mem_rdata,
    // statistics
    output logic [15:0]   stat_stall_cnt,
    output logic [15:0]   stat_dma_cnt
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    typedef enum logic {
        CPU_OWN    = 1'b0,
        DMA_LOCKED = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          rvalid_q, rvalid_d;
    logic [WD-1:0] rdata_q, rdata_d;

    logic cpu_act;
    logic starve_hit;
    logic lock_end;
    logic sel_dma;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CPU_OWN;
            starve_q <= '0;
            lock_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            lock_q   <= lock_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Grant decision, next state, port mux and counter updates
    always_comb begin
        cpu_act    = memreadM | memwriteM;
        starve_hit = (starve_q == SW'(STARVE_LIMIT));
        lock_end   = (lock_q == LW'(LOCK_MAX - 1));
        state_d    = state_q;
        sel_dma    = 1'b0;

        // reset gates the grant so no DMA access leaks out while rst_n is low
        unique case (state_q)
            CPU_OWN: begin
                sel_dma = rst_n & dma_req & (~cpu_act | starve_hit);
                if (sel_dma && dma_lock) begin
                    state_d = DMA_LOCKED;
                end
            end
            DMA_LOCKED: begin
                sel_dma = rst_n & dma_req;
                if ((sel_dma && !dma_lock) || !dma_req || lock_end) begin
                    state_d = CPU_OWN;
                end
            end
            default: state_d = CPU_OWN;
        endcase

        dma_gnt   = sel_dma;
        stallM    = cpu_act & sel_dma;
        mem_addr  = sel_dma ? dma_addr  : aluresultM;
        mem_wdata = sel_dma ? dma_wdata : writedataM;
        mem_ctrl  = sel_dma ? dma_ctrl  : memctrlM;
        mem_re    = sel_dma ? ~dma_we : (memreadM  & rst_n);
        mem_we    = sel_dma ?  dma_we : (memwriteM & rst_n);
        readdataM = (!sel_dma && memreadM) ? mem_rdata : '0;

        // a grant (including the last one of a forced release) clears starvation
        if (!dma_req || sel_dma) begin
            starve_d = '0;
        end else if (starve_hit) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + SW'(1);
        end

        lock_d   = (state_q == DMA_LOCKED) ? lock_q + LW'(1) : '0;
        rvalid_d = sel_dma & ~dma_we;
        rdata_d  = rvalid_d ? mem_rdata : rdata_q;
    end

    assign dma_rvalid = rvalid_q;
    assign dma_rdata  = rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] dma_cnt_q;

    // Saturating stall-cycle and DMA-grant counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            dma_cnt_q   <= '0;
        end else begin
            if (stallM && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (dma_gnt && dma_cnt_q != 16'hFFFF) begin
                dma_cnt_q <= dma_cnt_q + 16'd1;
            end
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_dma_cnt   = dma_cnt_q;
`else
    assign stat_stall_cnt = 16'd0;
    assign stat_dma_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small word-wide memory model.
module tb_dmem_arbiter;

    localparam int unsigned WD  = 32;
    localparam int unsigned WAM = 17;

`ifdef DMEM_ARB_STATS_EN
    localparam logic [31:0] STAT_EXP = 32'd10;
`else
    localparam logic [31:0] STAT_EXP = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          memreadM, memwriteM;
    logic [WAM:0]  aluresultM;
    logic [WD-1:0] writedataM;
    logic [2:0]    memctrlM;
    logic [WD-1:0] readdataM;
    logic          stallM;
    logic          dma_req, dma_we, dma_lock;
    logic [WAM:0]  dma_addr;
    logic [WD-1:0] dma_wdata;
    logic [2:0]    dma_ctrl;
    logic          dma_gnt;
    logic [WD-1:0] dma_rdata;
    logic          dma_rvalid;
    logic [WAM:0]  mem_addr;
    logic          mem_we, mem_re;
    logic [2:0]    mem_ctrl;
    logic [WD-1:0] mem_wdata;
    logic [WD-1:0] mem_rdata;
    logic [15:0]   stat_stall_cnt, stat_dma_cnt;

    logic [WD-1:0] tbmem [0:255];
    logic          preloaded = 1'b0;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.WD(WD), .WAM(WAM), .STARVE_LIMIT(8), .LOCK_MAX(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .memreadM(memreadM), .memwriteM(memwriteM), .aluresultM(aluresultM),
        .writedataM(writedataM), .memctrlM(memctrlM), .readdataM(readdataM),
        .stallM(stallM),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ctrl(dma_ctrl), .dma_lock(dma_lock),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_ctrl(mem_ctrl), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stat_stall_cnt(stat_stall_cnt), .stat_dma_cnt(stat_dma_cnt)
    );

    always #5 clk = ~clk;

    // memory model: combinational read, posedge write, preloaded on first edge
    assign mem_rdata = tbmem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) tbmem[i] <= '0;
            tbmem[1]  <= 32'hDEADBEEF;
            tbmem[2]  <= 32'h22223333;
            preloaded <= 1'b1;
        end else if (mem_we) begin
            tbmem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_g;
        rst_n = 1'b0;
        memreadM = 1'b0; memwriteM = 1'b0; aluresultM = '0; writedataM = '0; memctrlM = 3'b000;
        dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b0; dma_ctrl = 3'b000;
        dma_addr = 18'h00100; dma_wdata = 32'h5555AAAA;

        // reset holds off the DMA write
        #3;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_gnt", dma_gnt, 0);
        chk("rst_stall", stallM, 0);
        chk("rst_rvalid", dma_rvalid, 0);
        chk("rst_rdata", dma_rdata, 0);
        tick(); tick();
        rst_n = 1'b1;
        #2;
        chk("post_rst_gnt", dma_gnt, 1);
        chk("post_rst_we", mem_we, 1);
        tick();
        dma_req = 1'b0; dma_we = 1'b0; aluresultM = 18'h00ABC;
        #2;
        chk("idle_we", mem_we, 0);
        chk("idle_re", mem_re, 0);
        chk("idle_addr", mem_addr, 32'h00ABC);
        chk("post_rst_write", tbmem[64], 32'h5555AAAA);

        // single DMA read, one-cycle latency
        dma_req = 1'b1; dma_addr = 18'h10004;
        #2;
        chk("rd_gnt", dma_gnt, 1);
        chk("rd_stall", stallM, 0);
        chk("rd_re", mem_re, 1);
        chk("rd_addr", mem_addr, 32'h10004);
        tick();
        dma_req = 1'b0;
        #2;
        chk("rd_rvalid", dma_rvalid, 1);
        chk("rd_rdata", dma_rdata, 32'hDEADBEEF);
        chk("rd_stall2", stallM, 0);
        tick();
        #2;
        chk("rd_rvalid_pulse", dma_rvalid, 0);
        chk("rd_rdata_hold", dma_rdata, 32'hDEADBEEF);

        // starvation: CPU loads every cycle, DMA wins every 9th cycle
        rst_n = 1'b0;
        memreadM = 1'b1; aluresultM = 18'h00008;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 18'h10004;
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            exp_g = (c % 9 == 0);
            #2;
            chk($sformatf("starve_gnt_c%0d", c), dma_gnt, exp_g);
            chk($sformatf("starve_stall_c%0d", c), stallM, exp_g);
            if (c == 1) chk("starve_cpu_data", readdataM, 32'h22223333);
            if (c == 9) chk("starve_cpu_data_gated", readdataM, 0);
            tick();
        end
        #2;
        chk("stat_dma_cnt", stat_dma_cnt, STAT_EXP);
        chk("stat_stall_cnt", stat_stall_cnt, STAT_EXP);

        // lock held high with CPU active: starvation entry, 16 locked cycles, forced release
        dma_lock = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            exp_g = (c == 9) || (c >= 10 && c <= 25) || (c == 34);
            #2;
            chk($sformatf("lock_gnt_c%0d", c), dma_gnt, exp_g);
            chk($sformatf("lock_stall_c%0d", c), stallM, exp_g);
            tick();
        end

        // reset in the middle of a lock blocks the pending DMA write
        memreadM = 1'b0; dma_we = 1'b1; dma_addr = 18'h00200; dma_wdata = 32'hBAD0BAD0;
        rst_n = 1'b0;
        #2;
        chk("midlock_rst_we", mem_we, 0);
        chk("midlock_rst_gnt", dma_gnt, 0);
        tick();
        chk("midlock_no_write", tbmem[128], 0);
        dma_req = 1'b0; dma_lock = 1'b0; dma_we = 1'b0;
        rst_n = 1'b1;
        tick();
        memreadM = 1'b1; dma_req = 1'b1;
        #2;
        chk("midlock_cpu_own", dma_gnt, 0);
        chk("midlock_cpu_served", stallM, 0);
        tick();
        memreadM = 1'b0; dma_req = 1'b0;
        tick();

        // locked 4-write burst, CPU store arrives on burst cycle 2
        for (int i = 0; i < 4; i++) begin
            dma_req = 1'b1; dma_we = 1'b1; dma_lock = (i < 3);
            dma_addr = 18'(32'h40 + 4 * i); dma_wdata = 32'h11110000 + 32'(i);
            if (i == 1) begin
                memwriteM = 1'b1; aluresultM = 18'h00044; writedataM = 32'hC0DEC0DE;
            end
            #2;
            chk($sformatf("burst_gnt_%0d", i), dma_gnt, 1);
            chk($sformatf("burst_stall_%0d", i), stallM, (i >= 1) ? 32'd1 : 32'd0);
            chk($sformatf("burst_addr_%0d", i), mem_addr, 32'h40 + 4 * i);
            tick();
        end
        dma_req = 1'b0; dma_lock = 1'b0; dma_we = 1'b0;
        #2;
        chk("burst_cpu_stall", stallM, 0);
        chk("burst_cpu_gnt", dma_gnt, 0);
        chk("burst_cpu_we", mem_we, 1);
        chk("burst_cpu_addr", mem_addr, 32'h44);
        chk("burst_cpu_wdata", mem_wdata, 32'hC0DEC0DE);
        tick();
        memwriteM = 1'b0;
        #2;
        chk("burst_mem0", tbmem[16], 32'h11110000);
        chk("burst_mem1", tbmem[17], 32'hC0DEC0DE);
        chk("burst_mem2", tbmem[18], 32'h11110002);
        chk("burst_mem3", tbmem[19], 32'h11110003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single byte-addressed data memory port between the CPU memory stage and a secondary bus master (DMA/debug loader).
- The CPU has default priority.
- A starvation counter guarantees the secondary master a slot.
- A bounded lock lets the secondary master own the memory for consecutive transfers while the CPU is stalled.

Parameters:
WD, 32, data width
WAM, 17, top address bit index; address width is WAM+1
STARVE_LIMIT, 8, denied DMA-request cycles before DMA wins over the CPU
LOCK_MAX, 16, max consecutive cycles in DMA_LOCKED before forced release

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
memreadM  in  1  CPU load
memwriteM  in  1  CPU store
aluresultM  in  WAM+1  CPU byte address
writedataM  in  WD  CPU store data
memctrlM  in  3  CPU access size code (010 byte store, 011 byte load, else word)
readdataM  out  WD  CPU load data
stallM  out  1  CPU access not served this cycle
dma_req  in  1  DMA transfer request
dma_we  in  1  1 = write, 0 = read
dma_addr  in  WAM+1  DMA byte address
dma_wdata  in  WD  DMA write data
dma_ctrl  in  3  DMA size code, same encoding as memctrlM
dma_lock  in  1  keep ownership after this transfer
dma_gnt  out  1  DMA transfer accepted this cycle
dma_rdata  out  WD  registered DMA read data
dma_rvalid  out  1  dma_rdata valid, one-cycle pulse
mem_addr  out  WAM+1  to memory
mem_we  out  1  to memory
mem_re  out  1  to memory
mem_ctrl  out  3  to memory
mem_wdata  out  WD  to memory
mem_rdata  in  WD  from memory (combinational read)

Behaviour:
- Definitions: cpu_act = memreadM | memwriteM. The memory reads combinationally and writes on posedge clk. One access per cycle.
- States:
  - CPU_OWN (reset state).
  - DMA_LOCKED.
- Grant decision, combinational:
  - In CPU_OWN, sel_dma = dma_req & (!cpu_act | starve_cnt == STARVE_LIMIT).
  - In DMA_LOCKED, sel_dma = dma_req.
- Outputs:
  - dma_gnt = sel_dma.
  - stallM = cpu_act & sel_dma.
  - Mux drives mem_* from DMA when sel_dma, else from CPU.
  - mem_re = sel_dma ? !dma_we : memreadM.
  - mem_we = sel_dma ? dma_we : memwriteM.
- readdataM = mem_rdata when !sel_dma & memreadM, else 0.
- DMA read latency 1: on accepted read, capture mem_rdata into dma_rdata at the next posedge and pulse dma_rvalid for 1 cycle. dma_rdata holds its value until the next DMA read.
- starve_cnt, width clog2(STARVE_LIMIT+1):
  - Cleared on dma_gnt or !dma_req.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - When starve_cnt = STARVE_LIMIT and the CPU is active, the DMA wins and the CPU stalls exactly 1 cycle.
- Transitions:
  - CPU_OWN -> DMA_LOCKED on dma_gnt & dma_lock.
  - DMA_LOCKED -> CPU_OWN on any of:
    - dma_gnt & !dma_lock
    - !dma_req
    - lock_cnt = LOCK_MAX-1
- lock_cnt:
  - Cleared on entry to DMA_LOCKED; increments each cycle in it.
  - On forced release, starve_cnt clears. The next DMA access arbitrates normally in CPU_OWN, even if dma_lock is still high.
- Simultaneous events:
  - CPU and DMA both idle: mem_re = mem_we = 0, mem_* follow the CPU inputs.
  - Entry and exit in the same cycle are impossible; entry needs dma_gnt.
- Reset (rst_n low, asynchronous):
  - Registered state: state = CPU_OWN, starve_cnt = 0, lock_cnt = 0, dma_rvalid = 0, dma_rdata = 0.
  - While rst_n is low, mem_we = 0, mem_re = 0, dma_gnt = 0 and stallM = 0, overriding the mux.
  - A mid-lock reset returns to CPU_OWN with no further DMA write performed.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN. Ports stat_stall_cnt (out, 16) and stat_dma_cnt (out, 16) always exist.
- With the macro:
  - stat_stall_cnt counts cycles with stallM = 1.
  - stat_dma_cnt counts dma_gnt cycles.
  - Both saturate at 16'hFFFF and clear on reset.
- Without the macro: both ports are driven constant 0 and no counter flops are built.

Test Plan:
- Reset with dma_req = 1, dma_we = 1 held during rst_n = 0 -> mem_we = 0, dma_gnt = 0. After release with CPU idle -> dma_gnt = 1 in the first cycle.
- CPU idle; DMA read at addr 0x10004 with memory word 0xDEADBEEF -> dma_gnt = 1 that cycle; next cycle dma_rvalid = 1, dma_rdata = 0xDEADBEEF; stallM = 0 throughout.
- CPU loads every cycle, DMA requests continuously, STARVE_LIMIT = 8 -> DMA denied 8 cycles, granted on cycle 9 with stallM = 1 for that one cycle, then the pattern repeats every 9 cycles.
- CPU idle; DMA locked burst of 4 writes (dma_lock = 1, 1, 1, 0); CPU store issued on burst cycle 2 -> stallM = 1 through burst cycle 4. The CPU store lands the cycle after, and the DMA data is not overwritten out of order.
- dma_lock held high with LOCK_MAX = 16 and the CPU active -> forced release after 16 locked cycles; CPU served on cycle 17 (stallM = 0); DMA regranted only via the starvation path.
- DMEM_ARB_STATS_EN defined, preceding starvation scenario run for 90 cycles -> stat_dma_cnt = 10, stat_stall_cnt = 10. Macro undefined -> both read 0.
